data_pipe_elastic: RTL
======================

// Module: data_pipe_elastic
// PURPOSE
//  Parametrised successor to the single-register DATA_I->DATA_O datapath stage in TOP.
//  Carries CHANNELS lanes of WIDTH bits each through DEPTH elastic register stages.
//  Uses a valid/ready handshake, a synchronous flush and an occupancy count.
//  Sits between a producer and a consumer that may stall. Gives fixed latency when unstalled
//  and lossless buffering when stalled.
// PARAMETERS
//  WIDTH     8  bits per channel (>=1)
//  CHANNELS  1  number of parallel lanes, packed lane0 in LSBs (>=1)
//  DEPTH     2  number of register stages = latency in cycles (>=1)
//  LVL_W     $clog2(DEPTH+1)  width of LEVEL_O (derived localparam, not overridable)
// PORTS
//  CLK_I    in   1               clock, all state on rising edge
//  RST_X    in   1               asynchronous active-low reset
//  DATA_I   in   WIDTH*CHANNELS  input word, all lanes
//  VALID_I  in   1               DATA_I holds a word
//  READY_O  out  1               block accepts DATA_I this cycle
//  DATA_O   out  WIDTH*CHANNELS  output word (registered, last stage)
//  VALID_O  out  1               DATA_O holds a word
//  READY_I  in   1               consumer accepts DATA_O this cycle
//  FLUSH_I  in   1               synchronous discard of all held words
//  LEVEL_O  out  LVL_W           number of occupied stages, 0..DEPTH
// BEHAVIOUR
//  Reset (RST_X=0, async): all stage valid bits 0, stage data 0.
//   Outputs: VALID_O=0, DATA_O=0, LEVEL_O=0, READY_O=1 (comb: stage0 empty).
//  Transfer rules:
//   - Input transfer when VALID_I&&READY_O. Output transfer when VALID_O&&READY_I.
//   - Stage k (0=input side, DEPTH-1=output) advances when it is empty or stage k+1 advances.
//     The last stage advances when it is empty or READY_I=1.
//   - READY_O = advance(stage0). Combinational ready ripple, no comb path VALID_I->VALID_O.
//  Latency: a word accepted at edge n appears with VALID_O=1 after edge n+DEPTH-1.
//   That is DEPTH register stages, VALID_O visible DEPTH-1 cycles after acceptance when
//   unstalled. Throughput is 1 word/cycle with READY_I held 1.
//  Stall: READY_I=0 holds DATA_O/VALID_O stable. Upstream bubbles still collapse.
//   READY_O falls only when all DEPTH stages are full.
//  Full (LEVEL_O==DEPTH) with READY_I=1: accept and emit in the same cycle, LEVEL_O unchanged.
//  Empty: VALID_O=0, DATA_O keeps its last value (not cleared). Don't-care for the consumer.
//  LEVEL_O: registered. Next value = LEVEL_O + in_xfer - out_xfer. Never exceeds DEPTH,
//   never wraps below 0. Bench asserts this.
//  FLUSH_I=1 at edge: all valid bits and LEVEL_O go to 0.
//   An input offered in the same cycle is dropped: READY_O forced 0 while FLUSH_I=1.
//   The output word in that cycle is still considered transferred if VALID_O&&READY_I.
//   Data registers are not cleared.
//  Reset mid-stream: all words lost immediately. No partial output. READY_O=1 after release.
//  Lanes are independent bit slices. No arithmetic on data, no lane reordering.
//  Protocol: VALID_I must not drop without a transfer. Violations are not detected.
// STRUCTURE
//  Package data_pipe_pkg:
//   - default WIDTH/CHANNELS/DEPTH constants.
//   - function clog2.
//   - lane slice helper macro/function lane(word, idx).
//  Sub-module data_pipe_stage (one elastic register: data, valid, advance logic).
//   Instantiated DEPTH times in a generate loop.
//  Top: stage chain, ready ripple, flush gating and level counter.
// TESTING
//  Bench clock period 200 time units. Stimulus driven with #1 delay after posedge.
//  1 reset: RST_X=0 for 2 cycles -> VALID_O=0, DATA_O=0, LEVEL_O=0, READY_O=1.
//    Release, then DATA_I=8'h55 pulsed 1 cycle (defaults) -> DATA_O=8'h55, VALID_O=1
//    exactly DEPTH=2 edges after acceptance.
//  2 streaming: CHANNELS=4, WIDTH=8, READY_I=1, send 16 incrementing words 32'h03020100+4i
//    -> 16 outputs in order, no gaps, LEVEL_O stays 2 during steady state.
//  3 backpressure: DEPTH=4, READY_I=0, VALID_I=1 with words A0..A5
//    -> READY_O=0 after 4 accepts, LEVEL_O=4, DATA_O=A0 stable.
//    Release READY_I -> A0..A5 emitted in order, nothing lost or duplicated.
//  4 full + simultaneous: LEVEL_O=DEPTH, READY_I=1, VALID_I=1 -> one in, one out,
//    LEVEL_O unchanged, READY_O=1.
//  5 flush: 3 words held, FLUSH_I=1 with VALID_I=1 and 8'hAA -> next cycle LEVEL_O=0,
//    VALID_O=0. 8'hAA never appears on DATA_O.
//  6 async reset mid-stream: drop RST_X between clock edges with 3 words held
//    -> VALID_O=0 and LEVEL_O=0 before the next edge. Post-release, first output is
//    the first word sent after release.

Source files
------------

// File: rtl/data_pipe_pkg.sv
// Shared defaults, control struct and helpers for the elastic data pipe.
package data_pipe_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 1;
  localparam int DEF_DEPTH    = 2;

  typedef struct packed {
    logic valid;  // word presented to this stage
    logic flush;  // discard held word
    logic ld;     // stage advances this cycle
  } stage_ctl_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// Lane idx of a packed multi-lane word, lane0 in the LSBs.
`define DP_LANE(word, idx, w) word[(idx)*(w) +: (w)]

// File: rtl/data_pipe_elastic_if.sv
// Producer/consumer handshake bundle of the elastic data pipe.
interface data_pipe_elastic_if #(
  parameter int WIDTH    = data_pipe_pkg::DEF_WIDTH,
  parameter int CHANNELS = data_pipe_pkg::DEF_CHANNELS,
  parameter int DEPTH    = data_pipe_pkg::DEF_DEPTH
);
  import data_pipe_pkg::*;
  localparam int LVL_W = clog2(DEPTH + 1);

  logic [WIDTH*CHANNELS-1:0] DATA_I;
  logic                      VALID_I;
  logic                      READY_O;
  logic [WIDTH*CHANNELS-1:0] DATA_O;
  logic                      VALID_O;
  logic                      READY_I;
  logic                      FLUSH_I;
  logic [LVL_W-1:0]          LEVEL_O;

  modport slave (
    input  DATA_I, VALID_I, READY_I, FLUSH_I,
    output READY_O, DATA_O, VALID_O, LEVEL_O
  );
  modport master (
    output DATA_I, VALID_I, READY_I, FLUSH_I,
    input  READY_O, DATA_O, VALID_O, LEVEL_O
  );
endinterface

// File: rtl/data_pipe_stage.sv
// One elastic register of the data pipe: a word and its valid bit.
module data_pipe_stage
  import data_pipe_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic          gclk,
  input  logic          grst_n,
  input  stage_ctl_t    ctl,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] data,
  output logic          valid
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (ctl.flush)   valid <= 1'b0;
      else if (ctl.ld) valid <= ctl.valid;
      // Bubbles never overwrite data, so the output keeps its last real word.
      if (ctl.ld && ctl.valid) data <= in_data;
    end
  end
endmodule

// File: rtl/data_pipe_elastic.sv
// DEPTH-stage elastic pipe: stage chain, ready ripple, flush gating, occupancy count.
module data_pipe_elastic
  import data_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
)(
  input logic                CLK_I,
  input logic                RST_X,
  data_pipe_elastic_if.slave bus
);
  localparam int DW    = WIDTH * CHANNELS;
  localparam int LVL_W = clog2(DEPTH + 1);

  logic [DEPTH:0][DW-1:0] data_chain;
  logic [DEPTH:0]         vld_pipe;
  logic [DEPTH-1:0]       adv;
  logic [LVL_W-1:0]       level;
  logic                   in_xfer;
  logic                   out_xfer;

  // Index 0 is the producer side; index k+1 is the output of stage k.
  assign data_chain[0] = bus.DATA_I;
  assign vld_pipe[0]   = bus.VALID_I & ~bus.FLUSH_I;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_ctl_t ctl;
    // Unrolled ripple: stage k moves if any stage from k to the output has a hole.
    assign adv[k]    = bus.READY_I | ~(&vld_pipe[DEPTH:k+1]);
    assign ctl.valid = vld_pipe[k];
    assign ctl.flush = bus.FLUSH_I;
    assign ctl.ld    = adv[k];

    data_pipe_stage #(.DW(DW)) u_stage (
      .gclk    (CLK_I),
      .grst_n  (RST_X),
      .ctl     (ctl),
      .in_data (data_chain[k]),
      .data    (data_chain[k+1]),
      .valid   (vld_pipe[k+1])
    );
  end

  assign bus.READY_O = adv[0] & ~bus.FLUSH_I;
  assign bus.VALID_O = vld_pipe[DEPTH];
  assign bus.DATA_O  = data_chain[DEPTH];
  assign bus.LEVEL_O = level;

  assign in_xfer  = bus.VALID_I & bus.READY_O;
  assign out_xfer = bus.VALID_O & bus.READY_I;

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X)           level <= '0;
    else if (bus.FLUSH_I) level <= '0;
    else                  level <= level + LVL_W'(in_xfer) - LVL_W'(out_xfer);
  end
endmodule
